// File: rtl/prog_divide_counter_if.sv
// Control/status bundle for prog_divide_counter.
// master: the side that drives en/div/div_load and observes the divided outputs.
// slave : the divider itself.
interface prog_divide_counter_if #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 4
);
  logic             en;
  logic [WIDTH-1:0] div;
  logic             div_load;
  logic             div_ack;
  logic             fout;
  logic             tick;
  logic [TAPS-1:0]  taps;

  modport master (
    output en, div, div_load,
    input  div_ack, fout, tick, taps
  );

  modport slave (
    input  en, div, div_load,
    output div_ack, fout, tick, taps
  );
endinterface

// File: rtl/prog_divide_counter.sv
// prog_divide_counter: fully synchronous programmable clock divider on fin.
// Counts 0..N-1 while en is high and produces a near-50% fout, a one-cycle
// terminal-count tick (for use as a clock enable) and binary tap outputs.
// A new divisor is staged by div_load and takes effect on the next wrap
// (or immediately on the next edge while counting is frozen); div_ack
// pulses the cycle after it takes effect.
// Optional macro DIV_TAPS_EN: when defined, the tap counter is built and
// taps[i] toggles with period 2^(i+1)*N; when undefined, taps is all zeros.
module prog_divide_counter #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 4
) (
  input logic                   fin,
  input logic                   rst,
  prog_divide_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE1 = {{WIDTH{1'b0}}, 1'b1};

  // Architectural state
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_act;
  logic [WIDTH-1:0] pend_val;
  logic             pending;
  logic             fout_q;
  logic             tick_q;
  logic             ack_q;

  // Next-state values
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] n_nxt;
  logic [WIDTH-1:0] pend_val_nxt;
  logic             pending_nxt;
  logic             fout_nxt;
  logic             tick_nxt;
  logic             ack_nxt;

  // Decode helpers
  logic [WIDTH-1:0] div_sat;   // requested ratio with 0 mapped to 1
  logic [WIDTH-1:0] n_last;    // terminal count N-1
  logic [WIDTH:0]   half;      // ceil(N/2), one bit wider so N=2^WIDTH-1 cannot overflow
  logic             wrap;      // counter sits on its terminal count
  logic             apply;     // staged divisor takes effect on this edge
  logic             tap_inc;   // enabled wrap edge, advances the tap counter

  assign div_sat = (bus.div == '0) ? ONE : bus.div;
  assign n_last  = n_act - ONE;
  assign half    = ({1'b0, n_act} + ONE1) >> 1;
  assign wrap    = (cnt == n_last);
  // While frozen, a staged divisor is applied on the very next edge; while
  // running, it waits for the wrap so the current period always completes.
  assign apply   = pending && (!bus.en || wrap);
  assign tap_inc = bus.en && wrap;

  // Next-state logic for count, divisor staging and registered outputs
  always_comb begin
    cnt_nxt      = cnt;
    n_nxt        = n_act;
    pend_val_nxt = pend_val;
    pending_nxt  = pending;
    fout_nxt     = fout_q;
    tick_nxt     = 1'b0;
    ack_nxt      = apply;

    if (bus.en) begin
      if (wrap) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
      end else begin
        cnt_nxt  = cnt + ONE;
      end
      // New count 0 is below ceil(N/2) for any N, so using the old N here
      // is safe even on the edge where a new divisor is applied.
      fout_nxt = ({1'b0, cnt_nxt} < half);
    end else if (apply) begin
      // Frozen reprogram: restart the waveform at the top of its high phase.
      cnt_nxt  = '0;
      fout_nxt = 1'b1;
    end

    if (apply) begin
      n_nxt       = pend_val;
      pending_nxt = 1'b0;
    end

    // A load on the same edge as an apply re-arms with the fresh value;
    // the apply above has already consumed the previous pend_val.
    if (bus.div_load) begin
      pend_val_nxt = div_sat;
      pending_nxt  = 1'b1;
    end
  end

  // State register with asynchronous reset to N=1, everything else cleared
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      n_act    <= ONE;
      pend_val <= '0;
      pending  <= 1'b0;
      fout_q   <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      n_act    <= n_nxt;
      pend_val <= pend_val_nxt;
      pending  <= pending_nxt;
      fout_q   <= fout_nxt;
      tick_q   <= tick_nxt;
      ack_q    <= ack_nxt;
    end
  end

  assign bus.fout    = fout_q;
  assign bus.tick    = tick_q;
  assign bus.div_ack = ack_q;

`ifdef DIV_TAPS_EN
  // Tap counter as a chain of toggle flops: bit i flips when every lower
  // bit is 1 on an enabled wrap edge, i.e. a plain binary increment.
  logic [TAPS-1:0] tap_q;
  logic [TAPS-1:0] carry;

  assign carry[0] = tap_inc;

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    if (i < TAPS - 1) begin : g_carry
      assign carry[i+1] = carry[i] & tap_q[i];
    end

    // Toggle flop for tap bit i
    always_ff @(posedge fin or posedge rst) begin
      if (rst)           tap_q[i] <= 1'b0;
      else if (carry[i]) tap_q[i] <= ~tap_q[i];
    end
  end

  assign bus.taps = tap_q;
`else
  logic unused_tap_inc;
  assign unused_tap_inc = tap_inc;
  assign bus.taps       = '0;
`endif

endmodule

// File: tb/tb_prog_divide_counter.sv
// Self-checking bench for prog_divide_counter: directed scenarios followed
// by a randomized run, every output compared each cycle with a reference
// model built from the divider's rules (count modulo N, wrap count for taps).
module tb_prog_divide_counter;
  localparam int WIDTH = 8;
  localparam int TAPS  = 4;

  logic fin = 1'b0;
  logic rst = 1'b0;

  prog_divide_counter_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus ();

  prog_divide_counter #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .fin (fin),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 fin = ~fin;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers)
  int m_cnt, m_n, m_pval, m_wraps;
  bit m_pend;
  int e_fout, e_tick, e_ack;

  function automatic void model_reset();
    m_cnt = 0; m_n = 1; m_pval = 0; m_pend = 0; m_wraps = 0;
    e_fout = 0; e_tick = 0; e_ack = 0;
  endfunction

  // One rising edge of fin with the given inputs.
  function automatic void model_edge(bit en, int dv, bit ld);
    e_tick = 0;
    e_ack  = 0;
    if (en) begin
      m_cnt = (m_cnt + 1) % m_n;
      if (m_cnt == 0) begin
        e_tick = 1;
        m_wraps++;
        if (m_pend) begin
          m_n = m_pval; m_pend = 0; e_ack = 1;
        end
      end
      e_fout = (m_cnt < (m_n + 1) / 2) ? 1 : 0;
    end else if (m_pend) begin
      m_n = m_pval; m_pend = 0; e_ack = 1;
      m_cnt = 0; e_fout = 1;
    end
    if (ld) begin
      m_pval = (dv == 0) ? 1 : dv;
      m_pend = 1;
    end
  endfunction

  function automatic int exp_taps();
`ifdef DIV_TAPS_EN
    return m_wraps % (1 << TAPS);
`else
    return 0;
`endif
  endfunction

  task automatic check(string tag, int obs, int expv);
    n_cmp++;
    assert (obs === expv)
      else begin
        n_bad++;
        $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
      end
  endtask

  task automatic check_outs(string tag);
    check({tag, ".fout"},    int'(bus.fout),    e_fout);
    check({tag, ".tick"},    int'(bus.tick),    e_tick);
    check({tag, ".div_ack"}, int'(bus.div_ack), e_ack);
    check({tag, ".taps"},    int'(bus.taps),    exp_taps());
  endtask

  // Drive inputs mid-cycle, advance one edge, compare just after the edge.
  task automatic step(string tag, bit en, int dv, bit ld);
    @(negedge fin);
    bus.en       = en;
    bus.div      = dv[WIDTH-1:0];
    bus.div_load = ld;
    @(posedge fin);
    model_edge(en, dv, ld);
    #1;
    check_outs(tag);
  endtask

  task automatic run(string tag, bit en, int cycles);
    for (int k = 0; k < cycles; k++) step(tag, en, 0, 1'b0);
  endtask

  // Run enabled until the model count reaches target (bounded).
  task automatic run_to_cnt(string tag, int target);
    for (int k = 0; k < 300 && m_cnt != target; k++) step(tag, 1'b1, 0, 1'b0);
  endtask

  initial begin
    bus.en = 1'b0; bus.div = '0; bus.div_load = 1'b0;
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge fin);
    #1 check_outs("reset");
    @(negedge fin) rst = 1'b0;
    #1 check_outs("post_reset");

    // Default N=1: tick every cycle, fout constant 1, taps count wraps
    run("n1", 1'b1, 40);

    // Load 4 while N=1: ack almost immediately, then 1,1,0,0 pattern
    step("load4", 1'b1, 4, 1'b1);
    run("n4", 1'b1, 40);

    // N=5 for 100 periods: 3 high / 2 low, tick every 5
    step("load5", 1'b1, 5, 1'b1);
    run("n5", 1'b1, 505);

    // Back-to-back loads inside one period: only the last one is applied
    run_to_cnt("align", 0);
    step("load6", 1'b1, 6, 1'b1);
    step("load3", 1'b1, 3, 1'b1);
    run("n3", 1'b1, 30);

    // Freeze at cnt=2, reprogram while frozen, then resume
    step("load5b", 1'b1, 5, 1'b1);
    run("n5b", 1'b1, 10);
    run_to_cnt("to_cnt2", 2);
    run("frozen", 1'b0, 6);
    step("load7_frz", 1'b0, 7, 1'b1);
    run("frz_apply", 1'b0, 3);
    run("n7", 1'b1, 35);

    // Asynchronous reset mid-count with N=9, cnt=6
    step("load9", 1'b1, 9, 1'b1);
    run("n9", 1'b1, 12);
    for (int k = 0; k < 300 && !(m_n == 9 && m_cnt == 6); k++) step("to_cnt6", 1'b1, 0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_outs("async_rst");
    @(negedge fin) rst = 1'b0;
    run("n1_again", 1'b1, 12);

    // div=0 behaves as N=1
    step("load0", 1'b1, 0, 1'b1);
    run("n0", 1'b1, 12);

    // Randomized: enables, loads (sometimes simultaneous with apply)
    for (int k = 0; k < 1500; k++) begin
      bit en_r, ld_r;
      int dv_r;
      en_r = ($urandom_range(0, 3) != 0);
      ld_r = ($urandom_range(0, 15) == 0);
      dv_r = int'($urandom_range(0, 12));
      step("rand", en_r, dv_r, ld_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prog_divide_counter.md
Name: prog_divide_counter

Overview:
Parametrised, fully synchronous successor to the fixed ripple divide-by-2/4/8/16 counter. It divides the input clock fin by a run-time programmable ratio N and produces:
- fout, a near-50% duty divided waveform;
- tick, a one-cycle terminal-count enable;
- taps, a cascade of binary sub-divided outputs (fout/2, fout/4, ...).

No derived clocks are used: every flop is on fin. Downstream logic uses tick as a clock enable.

Parameters:
WIDTH, 8, width of divisor input and internal count (N range 1..2^WIDTH-1)
TAPS, 4, number of binary tap outputs

Ports:
fin  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; low freezes counting
div  input  WIDTH  requested divide ratio N; value 0 treated as 1
div_load  input  1  one-cycle strobe capturing div into pending register
div_ack  output  1  one-cycle pulse when pending divisor takes effect
fout  output  1  divided output, period N enabled cycles
tick  output  1  one-cycle pulse per N enabled cycles
taps  output  TAPS  taps[i] toggles period 2^(i+1)*N enabled cycles

Behaviour:
- One clock: fin. Reset is asynchronous, active-high: rst.
- Reset values: cnt=0, active divisor N=1, pending=0, pend_val=0, fout=0, tick=0, div_ack=0, taps=0, tap counter=0.
- Counter: when en=1, cnt advances 0,1,..,N-1 then wraps to 0. When en=0, cnt holds.
- tick: registered. tick=1 for exactly the cycle after the edge on which cnt wraps (N-1 -> 0) with en=1; otherwise 0. N=1 gives tick=1 on every cycle following an enabled edge.
- fout: registered together with cnt. fout=1 iff new cnt < ceil(N/2).
  - Even N gives exactly 50% duty.
  - Odd N is high for one extra cycle.
  - N=1 gives fout constantly 1 once enabled.
  - After reset, fout stays 0 until the first enabled edge.
- Divisor load:
  - div_load=1 captures div into pend_val and sets pending. div=0 is stored as 1.
  - A further load while pending overwrites pend_val (last wins).
- Divisor apply:
  - Normal case: with en=1, pending applies at the wrap edge. N<=pend_val, cnt->0, pending cleared, div_ack=1 next cycle. The new N governs the count starting at cnt=0.
  - With en=0: pending applies on the next edge. cnt forced to 0, fout forced to 1, tick=0, div_ack pulses.
  - cnt never exceeds N-1, including when N is reduced.
- Simultaneous load and apply on the same edge: the apply uses the old pend_val, the new div becomes pend_val, and pending stays set.
- Taps: TAPS-bit binary counter incremented on each wrap edge with en=1; taps = counter value. Holds when en=0. Not cleared by divisor changes.
- Mid-operation reset forces all state to reset values immediately, independent of fin.
- Latency: div_load to div_ack takes at most N+1 cycles when en=1, and 2 cycles when en=0.

Optional Feature:
DIV_TAPS_EN
- Defined: tap counter instantiated; taps behaves as above.
- Undefined: no tap counter; taps tied to all zeros. fout, tick and the load/ack behaviour are unchanged.

Test Plan:
- Reset, en=1, N=1 default -> tick high every cycle, fout=1; with DIV_TAPS_EN, taps[0..3] toggle at fin/2, /4, /8, /16.
- Load div=4, en=1 -> div_ack within 2 cycles (N=1). Then fout pattern 1,1,0,0 repeating, tick once per 4 cycles, taps[0] period 8.
- N=5 -> fout high 3 cycles, low 2; tick period 5; no drift over 100 periods.
- Load div=6, then div=3 before the wrap -> only N=3 applied, a single div_ack, tick period 3 thereafter.
- en=0 mid-count with cnt=2 -> cnt, fout and taps frozen, tick=0. Load div=7 -> next edge cnt=0, fout=1, div_ack=1. Re-enable -> period 7.
- Assert rst mid-count (N=9, cnt=6) without a fin edge -> all outputs 0 immediately. After release, N=1 behaviour is restored. Load div=0 -> treated as N=1.
